// File: rtl/alu_pkg.sv
// alu_pkg: function codes, FSM encoding and legality check shared by the ALU front end.
// Revision 1.0
`default_nettype none

package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [5:0] code);
    return (code == FN_ADD) || (code == FN_SUB) || (code == FN_AND) ||
           (code == FN_OR)  || (code == FN_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ALU.sv
// ALU: 32-bit combinational ALU with a ripple-carry adder/subtractor.
// Revision 1.0
`default_nettype none

module ALU
  import alu_pkg::*;
(
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [31:0] dataOut
);

  logic        sub;
  logic [31:0] bx;
  logic [31:0] sum;
  logic [31:0] carry;

  assign sub      = (Signal == FN_SUB);
  assign bx       = dataB ^ {32{sub}};
  assign carry[0] = sub;

  // Long carry chain: the front end holds operands for several cycles before sampling.
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i] = dataA[i] ^ bx[i] ^ carry[i];
    if (i < 31) begin : g_carry
      assign carry[i+1] = (dataA[i] & bx[i]) | (carry[i] & (dataA[i] ^ bx[i]));
    end
  end

  always_comb begin
    dataOut = 32'd0;
    case (Signal)
      FN_ADD, FN_SUB: dataOut = sum;
      FN_AND:         dataOut = dataA & dataB;
      FN_OR:          dataOut = dataA | dataB;
      default:        dataOut = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin valid/ready front end sharing one multicycle ALU between two requesters.
// Revision 1.0
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_dataA,
  input  logic [31:0] req0_dataB,
  input  logic [5:0]  req0_Signal,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_dataA,
  input  logic [31:0] req1_dataB,
  input  logic [5:0]  req1_Signal,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_dataOut,
  output logic        rsp0_err,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_dataOut,
  output logic        rsp1_err,
  input  logic        rsp1_ready,
  output logic        busy
);

  state_t      state, next_state;
  logic        last_grant, grant, accept, owner, owner_ready;
  logic [31:0] op_a, op_b, rsp_data, alu_out, result;
  logic [5:0]  op_code, alu_sig;
  logic [3:0]  cnt;
  logic        rsp_vld, rsp_err_r, slt_bit;

  // The requester not granted last wins a tie.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  assign accept      = reset && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept && !grant;
  assign req1_ready  = accept && grant;
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;
  assign busy        = (state != IDLE);

  assign alu_sig = (op_code == FN_SLT) ? FN_SUB : op_code;

  ALU u_alu (
    .dataA   (op_a),
    .dataB   (op_b),
    .Signal  (alu_sig),
    .dataOut (alu_out)
  );

  // Sign of the difference is wrong on overflow; operand signs decide when they differ.
  assign slt_bit = (op_a[31] ^ op_b[31]) ? op_a[31] : alu_out[31];
  assign result  = (op_code == FN_SLT) ? {31'd0, slt_bit} : alu_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = is_legal(grant ? req1_Signal : req0_Signal) ? EXEC : RESP;
      EXEC:    if (cnt == 4'd0) next_state = RESP;
      RESP:    if (rsp_vld && owner_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_code    <= 6'd0;
      cnt        <= 4'd0;
      rsp_vld    <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant ? req1_dataA  : req0_dataA;
            op_b       <= grant ? req1_dataB  : req0_dataB;
            op_code    <= grant ? req1_Signal : req0_Signal;
            owner      <= grant;
            last_grant <= grant;
            cnt        <= 4'(HOLD_CYCLES - 1);
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_data  <= result;
            rsp_err_r <= 1'b0;
            rsp_vld   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Illegal codes arrive here with no response yet; raise it one cycle later.
          if (!rsp_vld) begin
            rsp_data  <= 32'd0;
            rsp_err_r <= 1'b1;
            rsp_vld   <= 1'b1;
          end else if (owner_ready) begin
            rsp_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp0_valid   = rsp_vld && !owner;
  assign rsp1_valid   = rsp_vld && owner;
  assign rsp0_dataOut = rsp0_valid ? rsp_data : 32'd0;
  assign rsp1_dataOut = rsp1_valid ? rsp_data : 32'd0;
  assign rsp0_err     = rsp0_valid && rsp_err_r;
  assign rsp1_err     = rsp1_valid && rsp_err_r;

endmodule

`default_nettype wire
